piso: RTL and testbench
=======================

PISO -- requirements
Module: piso

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width; legal range is >= 2.
REQ-002 SHALL have parameter LSB_FIRST, default 0; 0 selects MSB first and 1 selects LSB first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port load_valid, input, 1 bit: a parallel word is offered.
REQ-006 SHALL have port load_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 SHALL have port parallel_data_in, input, WIDTH bits: the word to serialize.
REQ-008 SHALL have port serial_data_out, output, 1 bit: the current serial bit, registered.
REQ-009 SHALL have port serial_valid, output, 1 bit: serial_data_out carries a frame bit this cycle.
REQ-010 SHALL have port last_bit, output, 1 bit: the current serial bit is the final bit of the frame.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-012 SHALL accept a word only on a rising edge where load_valid and load_ready are both 1, capturing parallel_data_in into an internal shift register.
REQ-013 SHALL implement states IDLE and SHIFT, plus PARITY when PISO_PARITY_EN is defined.
- IDLE -> SHIFT on accept.
- SHIFT -> IDLE after the final frame bit if there is no new accept.
- SHIFT stays in SHIFT, starting a new frame, on an accept during the final bit.
REQ-014 SHALL present the first data bit in the cycle immediately after the accept edge, then one bit per cycle for WIDTH consecutive cycles, with serial_valid = 1 for each of them.
REQ-015 SHALL, for bit order:
- LSB_FIRST = 0: emit bit WIDTH-1 down to bit 0.
- LSB_FIRST = 1: emit bit 0 up to bit WIDTH-1.
REQ-016 SHALL maintain a bit counter of width clog2(WIDTH+1) that counts frame bits and does not wrap or overflow for any legal WIDTH.
REQ-017 SHALL assert last_bit for exactly one cycle per frame, on the final frame bit.
REQ-018 SHALL drive load_ready = 1 in IDLE and during the final frame bit, and 0 otherwise; this allows back-to-back frames with no idle gap.
REQ-019 SHALL ignore parallel_data_in and load_valid while load_ready = 0; captured data SHALL NOT be altered mid-frame.
REQ-020 SHALL hold serial_data_out = 0, serial_valid = 0 and last_bit = 0 whenever no frame bit is being presented.
REQ-021 SHALL drive busy = 1 from the cycle after an accept through the final frame bit, and 0 otherwise.

Reset
REQ-022 SHALL, on any rising edge with rst = 1, force:
- state to IDLE and the bit counter to 0;
- the shift register to 0;
- serial_data_out, serial_valid, last_bit and busy to 0.
REQ-023 SHALL drive load_ready = 0 while rst = 1 and 1 from the first cycle after rst deasserts.
REQ-024 SHALL, when rst is asserted mid-frame, abort the frame from the next cycle with no partial bits resumed afterwards; rst SHALL take priority over a simultaneous accept.

Configuration
REQ-025 SHALL, when macro PISO_PARITY_EN is defined:
- append one even-parity bit, equal to the XOR of the captured word, after the WIDTH data bits;
- apply serial_valid = 1 and last_bit = 1 to the parity bit, not to the last data bit;
- raise load_ready during the parity cycle, not during the last data bit.
REQ-026 SHALL, when PISO_PARITY_EN is undefined, produce frames of exactly WIDTH bits and omit the PARITY state and parity logic entirely.

Verification (WIDTH = 4)
REQ-027 SHALL cover MSB-first framing: LSB_FIRST = 0, accept 4'b1011 -> serial 1,0,1,1 on 4 consecutive cycles; serial_valid high for 4 cycles; last_bit on the 4th; busy low on the 5th.
REQ-028 SHALL cover LSB-first framing: LSB_FIRST = 1, accept 4'b1011 -> serial 1,1,0,1.
REQ-029 SHALL cover back-to-back frames: load_valid held high with 4'hA, then 4'h5 offered on the last-bit cycle -> 8 contiguous valid bits 1,0,1,0,0,1,0,1; load_ready high only on cycles 4 and 8.
REQ-030 SHALL cover input stability: parallel_data_in changed to 4'h0 during 4'hC shifting, load_valid held high -> output 1,1,0,0 unchanged; 4'h0 is accepted only at the last-bit cycle.
REQ-031 SHALL cover reset mid-frame: rst pulsed during the 2nd bit of 4'hF -> all outputs 0 the next cycle; a subsequent accept of 4'h3 -> 0,0,1,1 with a clean last_bit.
REQ-032 SHALL cover parity framing: with PISO_PARITY_EN defined, accept 4'b1011 -> 1,0,1,1,1 with last_bit on the 5th bit; accept 4'b0011 -> parity bit 0.

Source files
------------

// File: rtl/piso.sv
// Parallel-in serial-out shifter with valid/ready load handshake and back-to-back framing.
// Define PISO_PARITY_EN to append an even-parity bit after the WIDTH data bits.
module piso #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] parallel_data_in,
   output logic             serial_data_out,
   output logic             serial_valid,
   output logic             last_bit,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
`ifdef PISO_PARITY_EN
      ST_PARITY = 2'd2,
`endif
      ST_SHIFT  = 2'd1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               serial_data_q, serial_data_d;
   logic               serial_valid_q, serial_valid_d;
   logic               last_bit_q, last_bit_d;
   logic               busy_q, busy_d;
`ifdef PISO_PARITY_EN
   logic               parity_q, parity_d;
`endif

   logic               accept_c;
   logic               last_data_c;

   // Ready in IDLE or while the final frame bit is on the wire; never during reset.
   assign load_ready  = !rst && ((state_q == ST_IDLE) || last_bit_q);
   assign accept_c    = load_valid && load_ready;
   assign last_data_c = (cnt_q == CNT_W'(WIDTH));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (last_data_c) begin
`ifdef PISO_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = accept_c ? ST_SHIFT : ST_IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         ST_PARITY: begin
            state_d = accept_c ? ST_SHIFT : ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next values; an accept always restarts a frame with its first bit
   always_comb begin
      shreg_d        = shreg_q;
      cnt_d          = cnt_q;
      serial_data_d  = 1'b0;
      serial_valid_d = 1'b0;
      last_bit_d     = 1'b0;
      busy_d         = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d       = parity_q;
`endif
      if (accept_c) begin
         serial_data_d  = LSB_FIRST ? parallel_data_in[0] : parallel_data_in[WIDTH-1];
         shreg_d        = LSB_FIRST ? (parallel_data_in >> 1) : (parallel_data_in << 1);
         cnt_d          = CNT_W'(1);
         serial_valid_d = 1'b1;
         busy_d         = 1'b1;
`ifdef PISO_PARITY_EN
         parity_d       = ^parallel_data_in;
`endif
      end else if ((state_q == ST_SHIFT) && !last_data_c) begin
         serial_data_d  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
         shreg_d        = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
         cnt_d          = CNT_W'(cnt_q + 1'b1);
         serial_valid_d = 1'b1;
         busy_d         = 1'b1;
`ifndef PISO_PARITY_EN
         last_bit_d     = (cnt_q == CNT_W'(WIDTH - 1));
`endif
`ifdef PISO_PARITY_EN
      end else if (state_q == ST_SHIFT) begin
         serial_data_d  = parity_q;
         serial_valid_d = 1'b1;
         busy_d         = 1'b1;
         last_bit_d     = 1'b1;
         cnt_d          = '0;
`endif
      end else begin
         cnt_d = '0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q        <= '0;
         cnt_q          <= '0;
         serial_data_q  <= 1'b0;
         serial_valid_q <= 1'b0;
         last_bit_q     <= 1'b0;
         busy_q         <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q       <= 1'b0;
`endif
      end else begin
         shreg_q        <= shreg_d;
         cnt_q          <= cnt_d;
         serial_data_q  <= serial_data_d;
         serial_valid_q <= serial_valid_d;
         last_bit_q     <= last_bit_d;
         busy_q         <= busy_d;
`ifdef PISO_PARITY_EN
         parity_q       <= parity_d;
`endif
      end
   end

   assign serial_data_out = serial_data_q;
   assign serial_valid    = serial_valid_q;
   assign last_bit        = last_bit_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_piso.sv
// Bench for piso: MSB-first and LSB-first instances share stimulus; a queue-of-bits model
// is checked every cycle, and directed scenarios are pinned with literal expectations.
module tb_piso;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load_valid = 1'b0;
   logic [W-1:0] pdi = '0;

   logic rdy_m, sdo_m, val_m, last_m, busy_m;
   logic rdy_l, sdo_l, val_l, last_l, busy_l;

   piso #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_m),
      .parallel_data_in(pdi), .serial_data_out(sdo_m), .serial_valid(val_m),
      .last_bit(last_m), .busy(busy_m)
   );

   piso #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_l),
      .parallel_data_in(pdi), .serial_data_out(sdo_l), .serial_valid(val_l),
      .last_bit(last_l), .busy(busy_l)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Model: queue holds the bits still to appear on the wire; element 0 is on the wire now.
   bit   qm[$];
   bit   ql[$];
   logic m_acc;

   task automatic chk(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] d);
      for (int i = W - 1; i >= 0; i--) qm.push_back(d[i]);
      for (int i = 0; i < W; i++) ql.push_back(d[i]);
`ifdef PISO_PARITY_EN
      qm.push_back(^d);
      ql.push_back(^d);
`endif
   endtask

   always @(posedge clk) begin
      if (rst) begin
         qm.delete();
         ql.delete();
      end else begin
         m_acc = load_valid && (qm.size() <= 1);
         if (qm.size() > 0) void'(qm.pop_front());
         if (ql.size() > 0) void'(ql.pop_front());
         if (m_acc) push_frame(pdi);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("msb.serial_valid", val_m, qm.size() > 0);
         chk("msb.serial_data",  sdo_m, (qm.size() > 0) ? qm[0] : 1'b0);
         chk("msb.last_bit",     last_m, qm.size() == 1);
         chk("msb.busy",         busy_m, qm.size() > 0);
         chk("msb.load_ready",   rdy_m, !rst && (qm.size() <= 1));
         chk("lsb.serial_valid", val_l, ql.size() > 0);
         chk("lsb.serial_data",  sdo_l, (ql.size() > 0) ? ql[0] : 1'b0);
         chk("lsb.last_bit",     last_l, ql.size() == 1);
         chk("lsb.busy",         busy_l, ql.size() > 0);
         chk("lsb.load_ready",   rdy_l, !rst && (ql.size() <= 1));
      end
   end

   // Apply inputs just after a rising edge, return at the following falling edge.
   task automatic cyc(input logic lv, input logic [W-1:0] d, input logic r);
      @(posedge clk);
      #2;
      load_valid = lv;
      pdi        = d;
      rst        = r;
      @(negedge clk);
   endtask

   logic [5:0] e_sdo_m, e_sdo_l, e_val, e_last;
   logic [7:0] e_b2b_bits, e_b2b_rdy;
   logic [3:0] e_nib;
   logic [W-1:0] words [6];

   initial begin
`ifdef PISO_PARITY_EN
      e_sdo_m = 6'b101110;
      e_sdo_l = 6'b110110;
      e_val   = 6'b111110;
      e_last  = 6'b000010;
`else
      e_sdo_m = 6'b101100;
      e_sdo_l = 6'b110100;
      e_val   = 6'b111100;
      e_last  = 6'b000100;
`endif
      e_b2b_bits = 8'b1010_0101;
      e_b2b_rdy  = 8'b0001_0001;
      words[0] = 4'h0; words[1] = 4'hF; words[2] = 4'h6;
      words[3] = 4'h9; words[4] = 4'h1; words[5] = 4'h8;

      // Reset
      cyc(1'b0, '0, 1'b1);
      chk_en = 1'b1;
      cyc(1'b1, 4'h7, 1'b1);
      chk("reset.load_ready", rdy_m, 1'b0);
      chk("reset.serial_valid", val_m, 1'b0);
      chk("reset.busy", busy_m, 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("post_reset.load_ready", rdy_m, 1'b1);
      chk("post_reset.serial_valid", val_m, 1'b0);

      // Single frame of 1011, both bit orders
      cyc(1'b1, 4'b1011, 1'b0);
      chk("frame.ready_idle", rdy_m, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, '0, 1'b0);
         chk($sformatf("frame.msb_bit%0d", i), sdo_m, e_sdo_m[5-i]);
         chk($sformatf("frame.lsb_bit%0d", i), sdo_l, e_sdo_l[5-i]);
         chk($sformatf("frame.valid%0d", i), val_m, e_val[5-i]);
         chk($sformatf("frame.last%0d", i), last_m, e_last[5-i]);
         chk($sformatf("frame.busy%0d", i), busy_m, e_val[5-i]);
      end

      // Frame of 0011: parity bit is 0
      cyc(1'b1, 4'b0011, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("w3.bit4", sdo_m, 1'b1);
`ifdef PISO_PARITY_EN
      chk("w3.bit4_last", last_m, 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("w3.parity_bit", sdo_m, 1'b0);
      chk("w3.parity_valid", val_m, 1'b1);
      chk("w3.parity_last", last_m, 1'b1);
`else
      chk("w3.bit4_last", last_m, 1'b1);
      cyc(1'b0, '0, 1'b0);
      chk("w3.after_valid", val_m, 1'b0);
`endif
      cyc(1'b0, '0, 1'b0);

`ifndef PISO_PARITY_EN
      // Back-to-back A then 5
      cyc(1'b1, 4'hA, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i < 3)       cyc(1'b1, 4'hA, 1'b0);
         else if (i == 3) cyc(1'b1, 4'h5, 1'b0);
         else             cyc(1'b0, '0, 1'b0);
         chk($sformatf("b2b.bit%0d", i), sdo_m, e_b2b_bits[7-i]);
         chk($sformatf("b2b.valid%0d", i), val_m, 1'b1);
         chk($sformatf("b2b.ready%0d", i), rdy_m, e_b2b_rdy[7-i]);
      end
      cyc(1'b0, '0, 1'b0);
      chk("b2b.idle_valid", val_m, 1'b0);

      // Input changes mid-frame are ignored; 0 accepted on the last bit
      e_nib = 4'hC;
      cyc(1'b1, 4'hC, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 4'h0, 1'b0);
         chk($sformatf("stab.bit%0d", i), sdo_m, e_nib[3-i]);
         chk($sformatf("stab.ready%0d", i), rdy_m, i == 3);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, '0, 1'b0);
         chk($sformatf("stab.zero_valid%0d", i), val_m, 1'b1);
         chk($sformatf("stab.zero_bit%0d", i), sdo_m, 1'b0);
         chk($sformatf("stab.zero_last%0d", i), last_m, i == 3);
      end
      cyc(1'b0, '0, 1'b0);
      chk("stab.idle_valid", val_m, 1'b0);

      // Reset during the 2nd bit of F, then a clean frame of 3
      cyc(1'b1, 4'hF, 1'b0);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b1, 4'h3, 1'b1);
      chk("rstmid.bit2_valid", val_m, 1'b1);
      chk("rstmid.ready_in_rst", rdy_m, 1'b0);
      cyc(1'b1, 4'h3, 1'b0);
      chk("rstmid.sdo_cleared", sdo_m, 1'b0);
      chk("rstmid.valid_cleared", val_m, 1'b0);
      chk("rstmid.last_cleared", last_m, 1'b0);
      chk("rstmid.busy_cleared", busy_m, 1'b0);
      chk("rstmid.ready_after", rdy_m, 1'b1);
      e_nib = 4'h3;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, '0, 1'b0);
         chk($sformatf("rstmid.bit%0d", i), sdo_m, e_nib[3-i]);
         chk($sformatf("rstmid.last%0d", i), last_m, i == 3);
      end
      cyc(1'b0, '0, 1'b0);
      chk("rstmid.idle_last", last_m, 1'b0);
`endif

      // Assorted words with varying load_valid gaps, checked by the model
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, words[k], 1'b0);
         for (int j = 0; j < W + 1; j++) cyc(1'(j + k), ~words[k], 1'b0);
      end
      cyc(1'b1, 4'h6, 1'b0);
      cyc(1'b1, 4'h6, 1'b1);
      repeat (W + 3) cyc(1'b0, '0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
